// File: rtl/reg_scoreboard_if.sv
// Bundle between the ID stage / write-back port and the register scoreboard.
// Handshake: id_valid offers an ID instruction every cycle; the scoreboard answers in the
// same cycle with stall (hold it, retry next cycle) or issue (recorded on this rising edge).
// A flushed instruction (id_flush=1) is neither stalled nor issued.
interface reg_scoreboard_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              id_flush;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              stall;
    logic              issue;
    logic [5:0]        outstanding;
    logic              sb_err;

    // Pipeline side: drives ID/WB information, consumes stall/issue/status
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_is_load, id_flush, wb_regwrite, wb_rd,
        input  stall, issue, outstanding, sb_err
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_is_load, id_flush, wb_regwrite, wb_rd,
        output stall, issue, outstanding, sb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Producer-side register result tracker for the 5-stage pipeline.
// Per register: cnt = writes in flight, lat = stall cycles left before the newest
// result can be forwarded. Raises stall on a not-yet-forwardable operand (load-use)
// or when the destination's in-flight counter would overflow.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int ALU_LAT  = 0,
    parameter int OUT_W    = 2
) (
    input logic              clk,
    input logic              rst,
    reg_scoreboard_if.slave  sb
);
    localparam logic [OUT_W-1:0] CNT_MAX    = '1;
    localparam logic [1:0]       LOAD_LAT_V = 2'(LOAD_LAT);
    localparam logic [1:0]       ALU_LAT_V  = 2'(ALU_LAT);

    logic [OUT_W-1:0] cnt_q [NUM_REGS];
    logic [OUT_W-1:0] cnt_d [NUM_REGS];
    logic [1:0]       lat_q [NUM_REGS];
    logic [1:0]       lat_d [NUM_REGS];
    logic [5:0]       outstanding_q, outstanding_d;
    logic             sb_err_q, sb_err_d;

    logic id_live, hz_rs1, hz_rs2, hz_full, stall_w, issue_w;
    logic wb_live, retire_ok, wb_bad;

    // Hazard detection and issue decision; x0 never stalls and is never recorded
    always_comb begin
        id_live   = ~rst & sb.id_valid & ~sb.id_flush;
        hz_rs1    = sb.id_use_rs1 && (sb.id_rs1 != '0) && (lat_q[sb.id_rs1] != 2'd0);
        hz_rs2    = sb.id_use_rs2 && (sb.id_rs2 != '0) && (lat_q[sb.id_rs2] != 2'd0);
        hz_full   = sb.id_regwrite && (sb.id_rd != '0) && (cnt_q[sb.id_rd] == CNT_MAX);
        stall_w   = id_live & (hz_rs1 | hz_rs2 | hz_full);
        issue_w   = id_live & ~stall_w & sb.id_regwrite & (sb.id_rd != '0);
        wb_live   = sb.wb_regwrite && (sb.wb_rd != '0);
        retire_ok = wb_live && (cnt_q[sb.wb_rd] != '0);
        wb_bad    = wb_live && (cnt_q[sb.wb_rd] == '0);
    end

    // Next-state: lat counts down, issue loads lat (newest writer wins) and bumps cnt,
    // a valid retire drops cnt; issue+retire on one register nets to no change
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            lat_d[r] = (lat_q[r] != 2'd0) ? lat_q[r] - 2'd1 : 2'd0;
        end
        if (issue_w) begin
            cnt_d[sb.id_rd] = cnt_d[sb.id_rd] + OUT_W'(1);
            lat_d[sb.id_rd] = sb.id_is_load ? LOAD_LAT_V : ALU_LAT_V;
        end
        if (retire_ok) begin
            cnt_d[sb.wb_rd] = cnt_d[sb.wb_rd] - OUT_W'(1);
        end
        outstanding_d = outstanding_q + {5'd0, issue_w} - {5'd0, retire_ok};
        sb_err_d      = sb_err_q | wb_bad;
    end

    // State registers; reset discards every record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
                lat_q[r] <= 2'd0;
            end
            outstanding_q <= 6'd0;
            sb_err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
                lat_q[r] <= lat_d[r];
            end
            outstanding_q <= outstanding_d;
            sb_err_q      <= sb_err_d;
        end
    end

    assign sb.stall       = stall_w;
    assign sb.issue       = issue_w;
    assign sb.outstanding = outstanding_q;
    assign sb.sb_err      = sb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: load-use timing, ALU forwarding, x0,
// counter saturation, same-edge issue/retire, sticky error and async reset.
module tb_reg_scoreboard;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    reg_scoreboard_if #(.REG_AW(5)) bus ();

    reg_scoreboard u_dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.id_rd       = 5'd0;
        bus.id_regwrite = 1'b0;
        bus.id_is_load  = 1'b0;
        bus.id_flush    = 1'b0;
        bus.wb_regwrite = 1'b0;
        bus.wb_rd       = 5'd0;
    endtask

    // Present an ID instruction (wb fields untouched)
    task automatic drive_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd, input logic rw,
                            input logic ld);
        bus.id_valid    = 1'b1;
        bus.id_flush    = 1'b0;
        bus.id_rs1      = rs1;
        bus.id_use_rs1  = u1;
        bus.id_rs2      = rs2;
        bus.id_use_rs2  = u2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_is_load  = ld;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] rd);
        bus.wb_regwrite = en;
        bus.wb_rd       = rd;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // Outputs held quiet during reset even with a live ID instruction
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #2;
        check_eq("rst_stall", 32'(bus.stall), 0);
        check_eq("rst_issue", 32'(bus.issue), 0);
        check_eq("rst_outstanding", 32'(bus.outstanding), 0);
        check_eq("rst_sb_err", 32'(bus.sb_err), 0);
        tick();
        tick();
        idle();
        rst = 1'b0;
        tick();

        // 1: build cnt[5]=2, lat[5]=1 plus an error, then reset mid-run
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        drive_wb(1'b1, 5'd20);
        tick();
        drive_wb(1'b0, 5'd0);
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        idle();
        check_eq("t1_pre_outstanding", 32'(bus.outstanding), 2);
        check_eq("t1_pre_sb_err", 32'(bus.sb_err), 1);
        rst = 1'b1;
        #1;
        check_eq("t1_rst_outstanding", 32'(bus.outstanding), 0);
        check_eq("t1_rst_sb_err", 32'(bus.sb_err), 0);
        rst = 1'b0;
        tick();
        // Stale lat[5] must be gone: an x5 reader issues at once
        drive_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check_eq("t1_no_stale_stall", 32'(bus.stall), 0);
        tick();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        check_eq("t1_load_issue", 32'(bus.issue), 1);
        tick();
        drive_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        check_eq("t1_use_stall", 32'(bus.stall), 1);
        check_eq("t1_use_no_issue", 32'(bus.issue), 0);
        tick();
        check_eq("t1_use_stall_done", 32'(bus.stall), 0);
        check_eq("t1_use_issue", 32'(bus.issue), 1);
        tick();
        check_eq("t1_outstanding", 32'(bus.outstanding), 2);

        // 2: ALU result is fully forwardable
        drive_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive_id(5'd3, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check_eq("t2_alu_stall", 32'(bus.stall), 0);
        check_eq("t2_alu_issue", 32'(bus.issue), 1);
        tick();
        check_eq("t2_outstanding", 32'(bus.outstanding), 4);

        // 3: load x7, reader on rs2 stalls exactly one cycle
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(5'd1, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0);
        #1;
        check_eq("t3_rs2_stall", 32'(bus.stall), 1);
        tick();
        check_eq("t3_rs2_stall_1cyc", 32'(bus.stall), 0);
        check_eq("t3_rs2_issue", 32'(bus.issue), 1);
        tick();
        check_eq("t3_outstanding", 32'(bus.outstanding), 6);

        // Flush while a load-use hazard exists: neither stall nor issue
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        tick();
        drive_id(5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        bus.id_flush = 1'b1;
        #1;
        check_eq("flush_stall", 32'(bus.stall), 0);
        check_eq("flush_issue", 32'(bus.issue), 0);
        tick();
        idle();
        check_eq("flush_outstanding", 32'(bus.outstanding), 7);

        // 4: x0 is never recorded and never stalls
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        #1;
        check_eq("t4_x0_issue", 32'(bus.issue), 0);
        check_eq("t4_x0_stall", 32'(bus.stall), 0);
        tick();
        drive_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        check_eq("t4_x0_reader_stall", 32'(bus.stall), 0);
        tick();
        check_eq("t4_outstanding", 32'(bus.outstanding), 7);

        // 5: saturate cnt[9] then a fourth write waits for a retire
        for (int i = 0; i < 3; i++) begin
            drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
            #1;
            check_eq("t5_fill_issue", 32'(bus.issue), 1);
            tick();
        end
        check_eq("t5_outstanding_full", 32'(bus.outstanding), 10);
        #1;
        check_eq("t5_full_stall", 32'(bus.stall), 1);
        check_eq("t5_full_no_issue", 32'(bus.issue), 0);
        tick();
        check_eq("t5_full_stall_hold", 32'(bus.stall), 1);
        drive_wb(1'b1, 5'd9);
        #1;
        check_eq("t5_full_stall_wb", 32'(bus.stall), 1);
        tick();
        drive_wb(1'b0, 5'd0);
        check_eq("t5_after_wb_outstanding", 32'(bus.outstanding), 9);
        check_eq("t5_after_wb_stall", 32'(bus.stall), 0);
        check_eq("t5_after_wb_issue", 32'(bus.issue), 1);
        tick();
        check_eq("t5_outstanding_end", 32'(bus.outstanding), 10);

        // 6: same-edge issue and retire of x4, then retire of an unrecorded x2
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        check_eq("t6_pre_outstanding", 32'(bus.outstanding), 11);
        drive_wb(1'b1, 5'd4);
        #1;
        check_eq("t6_same_edge_issue", 32'(bus.issue), 1);
        tick();
        idle();
        check_eq("t6_same_edge_outstanding", 32'(bus.outstanding), 11);
        check_eq("t6_no_err", 32'(bus.sb_err), 0);
        // cnt[4] still 1: one retire is accepted without error
        drive_wb(1'b1, 5'd4);
        tick();
        idle();
        check_eq("t6_x4_retire_outstanding", 32'(bus.outstanding), 10);
        check_eq("t6_x4_retire_no_err", 32'(bus.sb_err), 0);
        drive_wb(1'b1, 5'd2);
        tick();
        idle();
        check_eq("t6_err_set", 32'(bus.sb_err), 1);
        check_eq("t6_err_outstanding", 32'(bus.outstanding), 10);
        tick();
        tick();
        check_eq("t6_err_sticky", 32'(bus.sb_err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
